// File: rtl/sys_defs.sv
// Shared front-end types: instruction word and the fetch-queue entry layout.
package sys_defs;

  localparam int FQ_DEPTH = 8;

  typedef logic [31:0] inst_t;

  typedef struct packed {
    inst_t       inst;
    logic [31:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// 2-in/2-out fetch-to-decode queue; one-cycle latency, in_ready only when two entries are free by registered count.
// FETCH_QUEUE_BYPASS_EN: an empty queue forwards in_* straight to out_* and skips writing slots consumed that cycle.
module fetch_queue
  import sys_defs::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [1:0]                     in_valid,
  input  inst_t [1:0]                    in_inst,
  input  logic [1:0][31:0]               in_pc,
  output logic                           in_ready,
  output logic [1:0]                     out_valid,
  output inst_t [1:0]                    out_inst,
  output logic [1:0][31:0]               out_pc,
  input  logic [1:0]                     deq_count,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fq_entry_t         mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_next;

  logic [1:0]        vld_in;
  logic [1:0]        enq_n;
  logic [1:0]        deq_req;
  logic [1:0]        deq_eff;
  logic [1:0]        skip_n;
  logic [1:0]        wr_n;
  fq_entry_t [1:0]   in_ent;
  fq_entry_t [1:0]   wr_ent;
  fq_entry_t [1:0]   rd_ent;
  logic [1:0]        rd_vld;

  // Slot 1 only counts when slot 0 is also valid, keeping the stream contiguous.
  assign vld_in  = {in_valid[1] & in_valid[0], in_valid[0]};
  assign enq_n   = {1'b0, vld_in[0]} + {1'b0, vld_in[1]};
  assign in_ready = (count_q <= CW'(DEPTH - 2));

  assign deq_req = (deq_count == 2'd3) ? 2'd2 : deq_count;
  assign deq_eff = (CW'(deq_req) > count_q) ? count_q[1:0] : deq_req;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_ent[i].inst = in_inst[i];
      in_ent[i].pc   = in_pc[i];
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = (count_q == '0) && !flush;
  assign skip_n = !bypass ? 2'd0 : ((deq_req < enq_n) ? deq_req : enq_n);
`else
  assign skip_n = 2'd0;
`endif

  assign wr_n = (in_ready && !flush) ? (enq_n - skip_n) : 2'd0;

  // With one bypassed slot, the surviving slot 1 lands at the tail.
  assign wr_ent[0] = skip_n[0] ? in_ent[1] : in_ent[0];
  assign wr_ent[1] = in_ent[1];

  assign count_next = count_q + CW'(wr_n) - CW'(deq_eff);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PW'(deq_eff);
      tail    <= tail + PW'(wr_n);
      count_q <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    for (int j = 0; j < 2; j++) begin
      if (2'(j) < wr_n) begin
        mem[tail + PW'(j)] <= wr_ent[j];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rd_ent[i] = mem[head + PW'(i)];
      rd_vld[i] = (count_q > CW'(i));
    end
  end

  always_comb begin
    out_valid = rd_vld;
    for (int i = 0; i < 2; i++) begin
      out_inst[i] = rd_vld[i] ? rd_ent[i].inst : '0;
      out_pc[i]   = rd_vld[i] ? rd_ent[i].pc   : '0;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      out_valid = vld_in;
      for (int i = 0; i < 2; i++) begin
        out_inst[i] = vld_in[i] ? in_inst[i] : '0;
        out_pc[i]   = vld_in[i] ? in_pc[i]   : '0;
      end
    end
`endif
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: stimulus pushes expected entries, a negedge monitor pops them on consumption.
module tb_fetch_queue;
  import sys_defs::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       in_valid = '0;
  inst_t [1:0]      in_inst = '0;
  logic [1:0][31:0] in_pc = '0;
  logic             in_ready;
  logic [1:0]       out_valid;
  inst_t [1:0]      out_inst;
  logic [1:0][31:0] out_pc;
  logic [1:0]       deq_count = '0;
  logic [CW-1:0]    count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .deq_count(deq_count), .count(count)
  );

  always #5 clock = ~clock;

  fq_entry_t   expq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_count = 0;
  int          m_next  = 0;
  logic [31:0] next_pc = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic inst_t inst_of(input logic [31:0] pc);
    if (pc == 32'h0)      return 32'h0000_0013;
    else if (pc == 32'h4) return 32'h0010_0093;
    else                  return {pc[23:0], 8'h13};
  endfunction

  function automatic logic [1:0] exp_ov(input int c);
    return (c >= 2) ? 2'b11 : ((c == 1) ? 2'b01 : 2'b00);
  endfunction

  // Called at posedge+1: drives one cycle of stimulus and advances the reference model.
  task automatic drive_cycle(input logic [1:0] v, input logic [1:0] dq, input logic fl);
    int enq, deqr, acc, take;
    fq_entry_t e;
    in_valid  = v;
    deq_count = dq;
    flush     = fl;
    for (int i = 0; i < 2; i++) begin
      in_pc[i]   = next_pc + 32'(4 * i);
      in_inst[i] = inst_of(next_pc + 32'(4 * i));
    end
    enq  = v[0] ? (v[1] ? 2 : 1) : 0;
    deqr = (dq == 2'd3) ? 2 : int'(dq);
    acc  = (!fl && m_count <= DEPTH - 2) ? enq : 0;
    if (fl) begin
      expq.delete();
      m_next = 0;
    end else begin
      for (int i = 0; i < acc; i++) begin
        e.pc   = next_pc + 32'(4 * i);
        e.inst = inst_of(e.pc);
        expq.push_back(e);
      end
      next_pc = next_pc + 32'(4 * acc);
`ifdef FETCH_QUEUE_BYPASS_EN
      if (m_count == 0) begin
        take   = (deqr < acc) ? deqr : acc;
        m_next = acc - take;
      end else
`endif
      begin
        take   = (deqr < m_count) ? deqr : m_count;
        m_next = m_count + acc - take;
      end
    end
  endtask

  task automatic end_cycle();
    @(posedge clock);
    #1;
    m_count   = m_next;
    in_valid  = '0;
    deq_count = '0;
    flush     = 1'b0;
    chk("count", 32'(count), 32'(m_count));
    chk("in_ready", 32'(in_ready), 32'(m_count <= DEPTH - 2));
    chk("out_valid", 32'(out_valid), 32'(exp_ov(m_count)));
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] dq, input logic fl);
    drive_cycle(v, dq, fl);
    end_cycle();
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH && m_count > 0; k++) step(2'b00, 2'd2, 1'b0);
  endtask

  // Pops one expected entry per slot the decoder consumes at the coming edge.
  always @(negedge clock) begin
    if (!reset) begin
      int nd;
      fq_entry_t e;
      nd = (deq_count == 2'd3) ? 2 : int'(deq_count);
      for (int i = 0; i < 2; i++) begin
        if (i < nd && out_valid[i]) begin
          if (expq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pop_empty: slot %0d presented pc %h, expected no entry", i, out_pc[i]);
          end else begin
            e = expq.pop_front();
            chk("pop_pc", out_pc[i], e.pc);
            chk("pop_inst", out_inst[i], e.inst);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #9 reset = 1'b0;
    @(posedge clock);
    #1;

    // First pair: PCs 0x0/0x4 visible one cycle later
    step(2'b11, 2'd0, 1'b0);
    chk("r030_count", 32'(count), 32'd2);
    chk("r030_pc0", out_pc[0], 32'h0);
    chk("r030_pc1", out_pc[1], 32'h4);
    chk("r030_inst0", out_inst[0], 32'h0000_0013);
    chk("r030_inst1", out_inst[1], 32'h0010_0093);
    drain();
    chk("empty_pc_mask", out_pc[0], 32'h0);
    chk("empty_inst_mask", out_inst[0], 32'h0);

    // Fill to full, then an enqueue must be dropped
    for (int k = 0; k < 4; k++) step(2'b11, 2'd0, 1'b0);
    chk("r031_full_count", 32'(count), 32'd8);
    chk("r031_full_rdy", 32'(in_ready), 32'd0);
    step(2'b11, 2'd0, 1'b0);
    chk("r031_drop_count", 32'(count), 32'd8);
    drain();

    // count=7 with enqueue+dequeue: enqueue dropped, count 5
    for (int k = 0; k < 3; k++) step(2'b11, 2'd0, 1'b0);
    step(2'b01, 2'd0, 1'b0);
    drive_cycle(2'b11, 2'd2, 1'b0);
    chk("r032_rdy", 32'(in_ready), 32'd0);
    end_cycle();
    chk("r032_count", 32'(count), 32'd5);
    drain();

    // Steady 2-in/2-out, wrapping both pointers several times
    for (int k = 0; k < 20; k++) step(2'b11, 2'd2, 1'b0);
    drain();

    // Flush beats a simultaneous enqueue
    step(2'b11, 2'd0, 1'b0);
    step(2'b11, 2'd0, 1'b0);
    step(2'b01, 2'd0, 1'b0);
    chk("r034_pre", 32'(count), 32'd5);
    step(2'b11, 2'd0, 1'b1);
    chk("r034_count", 32'(count), 32'd0);
    chk("r034_ov", 32'(out_valid), 32'd0);

    // deq_count=3 acts as 2; over-dequeue clamps to count
    step(2'b11, 2'd0, 1'b0);
    step(2'b01, 2'd0, 1'b0);
    step(2'b00, 2'd3, 1'b0);
    chk("deq3_count", 32'(count), 32'd1);
    chk("mask_pc1", out_pc[1], 32'h0);
    step(2'b00, 2'd2, 1'b0);
    chk("deq_clamp_count", 32'(count), 32'd0);

    // Reset in the middle of operation
    step(2'b11, 2'd0, 1'b0);
    step(2'b11, 2'd0, 1'b0);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_ov", 32'(out_valid), 32'd0);
    chk("midrst_rdy", 32'(in_ready), 32'd1);
    expq.delete();
    m_count = 0;
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    step(2'b11, 2'd1, 1'b0);
    drain();

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards combinationally; the consumed slot is not stored
    drive_cycle(2'b11, 2'd1, 1'b0);
    #2;
    chk("byp_pc0", out_pc[0], in_pc[0]);
    chk("byp_ov", 32'(out_valid), 32'd3);
    end_cycle();
    chk("byp_count", 32'(count), 32'd1);
    drain();
`endif

    step(2'b00, 2'd0, 1'b0);
    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
